control_unit: RTL and testbench
===============================

# control_unit

Hardwired control sequencer for the ALU-system datapath. It drives every select, function and enable input of the register file, ALU, address register file, instruction register, memory and the three datapath muxes. It reads the instruction back through `IROut`. Every instruction takes a fixed fetch-low / fetch-high / execute sequence.

## Interface
Parameters:
- none; all encodings are constants in `cu_pkg`.

Ports:
- `Clock` in 1 — single system clock, rising edge.
- `Reset` in 1 — asynchronous, active-low.
- `IROut` in 16 — instruction register contents.
- `RF_OutASel`, `RF_OutBSel`, `RF_FunSel` out 3 each.
- `RF_RegSel`, `RF_ScrSel` out 4 each.
- `ALU_FunSel` out 5.
- `ALU_WF` out 1.
- `ARF_OutCSel`, `ARF_OutDSel` out 2 each.
- `ARF_FunSel`, `ARF_RegSel` out 3 each.
- `IR_LH`, `IR_Write`, `Mem_WR`, `Mem_CS` out 1 each.
- `MuxASel`, `MuxBSel` out 2 each.
- `MuxCSel` out 1.
- `Halted` out 1 — HLT executed.
- `T_State` out 3 — current sequencer state, for debug.

## Operation
Encodings (all fixed in `cu_pkg`):
- RegSel bits: `RF_RegSel` = {R1,R2,R3,R4}, `RF_ScrSel` = {S1..S4}, `ARF_RegSel` = {PC,AR,SP}. A 1 enables the register; all-zero holds.
- FunSel: 000 DEC, 001 INC, 010 LOAD, 011 CLR.
- OutA/OutB: 000–011 select R1–R4.
- OutC/OutD: 00 PC, 10 AR, 11 SP.
- ALU FunSel: PASSA 10000, ADD 10100, SUB 10110, AND 10111, ORR 11000, XOR 11001.
- `Mem_CS` is active-low. `Mem_WR` = 1 means write.
- MuxA/MuxB: 00 ALUOut, 01 OutC, 10 MemOut, 11 IR[7:0].
- MuxC: 0 selects the low byte.

Instruction format:
- IR[15:10] is the opcode.
- Type 1: IR[9:8] = RSEL (R1–R4), IR[7:0] = immediate.
- Type 2: IR[8:6] = DST, IR[5:3] = SRC1, IR[2:0] = SRC2.

Opcodes (all execute in EXEC):
- 0x00 BRA: PC ← IR[7:0] via MuxB 11, ARF LOAD.
- 0x01 LDI: RSEL ← IR[7:0] via MuxA 11.
- 0x02 LD: RSEL ← M[AR]; OutD = AR, CS = 0, MuxA 10.
- 0x03 ST: M[AR] ← RSEL[7:0]; OutA = RSEL, PASSA, MuxC 0, WR = 1, CS = 0.
- 0x04 MOV: DST ← SRC1 via PASSA.
- 0x05–0x09 ADD/SUB/AND/ORR/XOR: DST ← SRC1 op SRC2, MuxA 00, `ALU_WF` = 1.
- 0x0A INC, 0x0B DEC: RF FunSel INC/DEC on RSEL.
- 0x0C HLT: go to HALT.
- Any other opcode, or a DST/SRC field with bit 2 set: NOP (all defaults for one cycle), then FETCH_L.

Default output values (all states, unless overridden):
- All RegSel/ScrSel = 0.
- `Mem_CS` = 1, `Mem_WR` = 0, `IR_Write` = 0, `ALU_WF` = 0.
- FunSel = LOAD.
- All other selects = 0.
- These are also the reset values of every output. `Halted` = 0 and `T_State` = INIT.

## Timing
States: INIT(0), FETCH_L(1), FETCH_H(2), EXEC(3), HALT(4).
- **INIT:** one cycle, entered only after `Reset` deasserts. Clears the whole register file and address register file: RF/ARF RegSel and ScrSel all ones, FunSel CLR. Next state FETCH_L.
- **FETCH_L:** OutD = PC, CS = 0, `IR_Write` = 1, `IR_LH` = 0, ARF PC INC. Next state FETCH_H.
- **FETCH_H:** same as FETCH_L but `IR_LH` = 1. Next state EXEC.
- **EXEC:** decodes `IROut` combinationally. Next state is FETCH_L, or HALT for HLT.
- **HALT:** all defaults and `Halted` = 1. Stays in HALT until `Reset`.
- Memory read is asynchronous. IR, RF, ARF and flags update on the rising edge that ends the state.
- Every non-HLT instruction takes exactly 3 cycles. PC advances by 2 per fetch.
- BRA overwrites PC in EXEC; the next fetch uses the new PC.
- `Reset` asserted at any point forces INIT and default outputs immediately, regardless of the clock. No datapath write happens on that edge.
- Outputs are a combinational function of state and `IROut` (Moore in fetch, Mealy on `IROut` in EXEC). No output registers.

## Structure
- `cu_pkg` holds:
  - state enum,
  - opcode constants,
  - FunSel/ALU/mux encodings,
  - register-select one-hot helper constants.
- One sub-module, `cu_decoder`: purely combinational. Maps {opcode, fields} to the EXEC output bundle plus an `illegal` flag. It keeps the state register and fetch logic in `control_unit` small.

## Test plan
- Reset release → INIT for one cycle: RF/ARF RegSel all ones with FunSel 011. Then FETCH_L with OutD = 00, IR_LH = 0, CS = 0.
- Memory bytes 0x2A, 0x05 at PC 0 (LDI R2, 0x2A) → EXEC shows RF_RegSel 0100, MuxASel 11, FunSel 010. PC = 2 after the fetch.
- ADD with DST = R1, SRC1 = R2, SRC2 = R3 (IR 0x1453) → OutASel 001, OutBSel 010, ALU_FunSel 10100, ALU_WF 1, RF_RegSel 1000.
- BRA 0x40 → ARF_RegSel 100, MuxBSel 11, FunSel LOAD. The next FETCH_L drives OutD = PC while PC = 0x40.
- HLT (0x3000) → Halted = 1 from the next cycle, with outputs at defaults for 10 cycles. Reset then restarts at INIT.
- Reset asserted mid-EXEC of ST → CS returns to 1 and WR to 0 with no clock edge. No memory write occurs.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the control sequencer: state enum, opcodes,
// FunSel / ALU / mux encodings, register-select helpers and the
// control bundle struct passed from the decoder to the top.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH_L = 3'd1,
    ST_FETCH_H = 3'd2,
    ST_EXEC    = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_LDI = 6'h01;
  localparam logic [5:0] OP_LD  = 6'h02;
  localparam logic [5:0] OP_ST  = 6'h03;
  localparam logic [5:0] OP_MOV = 6'h04;
  localparam logic [5:0] OP_ADD = 6'h05;
  localparam logic [5:0] OP_SUB = 6'h06;
  localparam logic [5:0] OP_AND = 6'h07;
  localparam logic [5:0] OP_ORR = 6'h08;
  localparam logic [5:0] OP_XOR = 6'h09;
  localparam logic [5:0] OP_INC = 6'h0A;
  localparam logic [5:0] OP_DEC = 6'h0B;
  localparam logic [5:0] OP_HLT = 6'h0C;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;

  localparam logic [4:0] ALU_PASSA = 5'b10000;
  localparam logic [4:0] ALU_ADD   = 5'b10100;
  localparam logic [4:0] ALU_SUB   = 5'b10110;
  localparam logic [4:0] ALU_AND   = 5'b10111;
  localparam logic [4:0] ALU_ORR   = 5'b11000;
  localparam logic [4:0] ALU_XOR   = 5'b11001;

  localparam logic [1:0] MUX_ALU  = 2'b00;
  localparam logic [1:0] MUX_OUTC = 2'b01;
  localparam logic [1:0] MUX_MEM  = 2'b10;
  localparam logic [1:0] MUX_IMM  = 2'b11;

  localparam logic [1:0] OCD_PC = 2'b00;
  localparam logic [1:0] OCD_AR = 2'b10;
  localparam logic [1:0] OCD_SP = 2'b11;

  localparam logic [2:0] ARF_PC  = 3'b100;
  localparam logic [2:0] ARF_ALL = 3'b111;
  localparam logic [3:0] RF_ALL  = 4'b1111;

  typedef struct packed {
    logic [2:0] rf_out_a_sel;
    logic [2:0] rf_out_b_sel;
    logic [2:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] rf_scr_sel;
    logic [4:0] alu_fun_sel;
    logic       alu_wf;
    logic [1:0] arf_out_c_sel;
    logic [1:0] arf_out_d_sel;
    logic [2:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctl_t;

  // Idle bundle: nothing enabled, memory deselected, FunSel LOAD.
  function automatic ctl_t ctl_default();
    ctl_t c;
    c             = '0;
    c.rf_fun_sel  = FS_LOAD;
    c.arf_fun_sel = FS_LOAD;
    c.mem_cs      = 1'b1;
    return c;
  endfunction

  // Type-2 register fields: 1..3 name R1..R3, 0 wraps to R4.
  // Fields with bit 2 set are rejected by the decoder before this is used.
  function automatic logic [1:0] reg_idx(input logic [2:0] f);
    return f[1:0] - 2'd1;
  endfunction

  // RegSel is {R1,R2,R3,R4}, so index 0 (R1) is the MSB.
  function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational EXEC-state decoder.
//   ir      : instruction register contents
//   ctl     : control bundle to drive in EXEC
//   illegal : unknown opcode or bad register field (bundle is then idle)
//   halt    : HLT decoded
module cu_decoder
  import cu_pkg::*;
(
  input  logic [15:0] ir,
  output ctl_t        ctl,
  output logic        illegal,
  output logic        halt
);

  logic [5:0] op;
  logic [1:0] rsel;
  logic [2:0] dst, src1, src2;

  assign op   = ir[15:10];
  assign rsel = ir[9:8];
  assign dst  = ir[8:6];
  assign src1 = ir[5:3];
  assign src2 = ir[2:0];

  always_comb begin
    ctl     = ctl_default();
    illegal = 1'b0;
    halt    = 1'b0;
    case (op)
      OP_BRA: begin
        ctl.arf_reg_sel = ARF_PC;
        ctl.arf_fun_sel = FS_LOAD;
        ctl.mux_b_sel   = MUX_IMM;
      end
      OP_LDI: begin
        ctl.rf_reg_sel = rf_onehot(rsel);
        ctl.mux_a_sel  = MUX_IMM;
      end
      OP_LD: begin
        ctl.rf_reg_sel    = rf_onehot(rsel);
        ctl.arf_out_d_sel = OCD_AR;
        ctl.mem_cs        = 1'b0;
        ctl.mux_a_sel     = MUX_MEM;
      end
      OP_ST: begin
        ctl.rf_out_a_sel  = {1'b0, rsel};
        ctl.alu_fun_sel   = ALU_PASSA;
        ctl.mux_c_sel     = 1'b0;
        ctl.arf_out_d_sel = OCD_AR;
        ctl.mem_wr        = 1'b1;
        ctl.mem_cs        = 1'b0;
      end
      OP_MOV: begin
        illegal          = dst[2] | src1[2];
        ctl.rf_out_a_sel = {1'b0, reg_idx(src1)};
        ctl.alu_fun_sel  = ALU_PASSA;
        ctl.mux_a_sel    = MUX_ALU;
        ctl.rf_reg_sel   = rf_onehot(reg_idx(dst));
      end
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR: begin
        illegal          = dst[2] | src1[2] | src2[2];
        ctl.rf_out_a_sel = {1'b0, reg_idx(src1)};
        ctl.rf_out_b_sel = {1'b0, reg_idx(src2)};
        ctl.alu_wf       = 1'b1;
        ctl.mux_a_sel    = MUX_ALU;
        ctl.rf_reg_sel   = rf_onehot(reg_idx(dst));
        case (op)
          OP_ADD:  ctl.alu_fun_sel = ALU_ADD;
          OP_SUB:  ctl.alu_fun_sel = ALU_SUB;
          OP_AND:  ctl.alu_fun_sel = ALU_AND;
          OP_ORR:  ctl.alu_fun_sel = ALU_ORR;
          default: ctl.alu_fun_sel = ALU_XOR;
        endcase
      end
      OP_INC: begin
        ctl.rf_reg_sel = rf_onehot(rsel);
        ctl.rf_fun_sel = FS_INC;
      end
      OP_DEC: begin
        ctl.rf_reg_sel = rf_onehot(rsel);
        ctl.rf_fun_sel = FS_DEC;
      end
      OP_HLT:  halt    = 1'b1;
      default: illegal = 1'b1;
    endcase
    // An illegal instruction must not leave any partial enables behind.
    if (illegal) ctl = ctl_default();
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: INIT -> (FETCH_L -> FETCH_H -> EXEC)* -> HALT.
// Outputs are combinational from state (and IROut in EXEC); holding Reset
// low forces idle outputs immediately, independent of the clock.
//   Clock, Reset (async, active-low), IROut (instruction register)
//   RF_* / ALU_* / ARF_* / IR_* / Mem_* / Mux*Sel : datapath controls
//   Halted : HLT executed;  T_State : current state for debug
module control_unit
  import cu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [2:0]  T_State
);

  state_t state, state_nxt;
  ctl_t   dec_ctl, ctl;
  logic   dec_illegal, dec_halt;

  cu_decoder u_dec (
    .ir      (IROut),
    .ctl     (dec_ctl),
    .illegal (dec_illegal),
    .halt    (dec_halt)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    ctl       = ctl_default();
    state_nxt = state;
    Halted    = 1'b0;
    if (Reset) begin
      case (state)
        ST_INIT: begin
          ctl.rf_reg_sel  = RF_ALL;
          ctl.rf_scr_sel  = RF_ALL;
          ctl.arf_reg_sel = ARF_ALL;
          ctl.rf_fun_sel  = FS_CLR;
          ctl.arf_fun_sel = FS_CLR;
          state_nxt       = ST_FETCH_L;
        end
        ST_FETCH_L, ST_FETCH_H: begin
          ctl.arf_out_d_sel = OCD_PC;
          ctl.mem_cs        = 1'b0;
          ctl.ir_write      = 1'b1;
          ctl.ir_lh         = (state == ST_FETCH_H);
          ctl.arf_reg_sel   = ARF_PC;
          ctl.arf_fun_sel   = FS_INC;
          state_nxt         = (state == ST_FETCH_L) ? ST_FETCH_H : ST_EXEC;
        end
        ST_EXEC: begin
          ctl       = dec_ctl;
          state_nxt = (dec_halt && !dec_illegal) ? ST_HALT : ST_FETCH_L;
        end
        ST_HALT: Halted = 1'b1;
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  assign RF_OutASel  = ctl.rf_out_a_sel;
  assign RF_OutBSel  = ctl.rf_out_b_sel;
  assign RF_FunSel   = ctl.rf_fun_sel;
  assign RF_RegSel   = ctl.rf_reg_sel;
  assign RF_ScrSel   = ctl.rf_scr_sel;
  assign ALU_FunSel  = ctl.alu_fun_sel;
  assign ALU_WF      = ctl.alu_wf;
  assign ARF_OutCSel = ctl.arf_out_c_sel;
  assign ARF_OutDSel = ctl.arf_out_d_sel;
  assign ARF_FunSel  = ctl.arf_fun_sel;
  assign ARF_RegSel  = ctl.arf_reg_sel;
  assign IR_LH       = ctl.ir_lh;
  assign IR_Write    = ctl.ir_write;
  assign Mem_WR      = ctl.mem_wr;
  assign Mem_CS      = ctl.mem_cs;
  assign MuxASel     = ctl.mux_a_sel;
  assign MuxBSel     = ctl.mux_b_sel;
  assign MuxCSel     = ctl.mux_c_sel;
  assign T_State     = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench: a tiny PC/AR/IR/memory model closes the fetch loop so
// the sequencer runs a real program; control outputs are checked against
// hand-computed values at negedges.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel, Halted;
  logic [2:0]  T_State;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
    .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .Halted(Halted), .T_State(T_State)
  );

  always #5 Clock = ~Clock;

  // ---- minimal datapath model ----
  logic [7:0]  mem [256];
  logic [7:0]  pc = 8'h55, ar = 8'h33, sp = 8'h77;
  logic [15:0] ir = 16'h0000;
  int          wr_cnt = 0;
  logic [7:0]  addr, ldv;

  assign IROut = ir;
  assign addr  = (ARF_OutDSel == 2'b10) ? ar : (ARF_OutDSel == 2'b11) ? sp : pc;
  assign ldv   = (MuxBSel == 2'b11) ? ir[7:0] : 8'h00;

  function automatic logic [7:0] arf_op(input logic [7:0] v, input logic [2:0] fs,
                                        input logic [7:0] ld);
    case (fs)
      3'b000:  return v - 8'd1;
      3'b001:  return v + 8'd1;
      3'b010:  return ld;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      if (IR_Write && !Mem_CS) begin
        if (IR_LH) ir[15:8] <= mem[addr];
        else       ir[7:0]  <= mem[addr];
      end
      if (!Mem_CS && Mem_WR) wr_cnt <= wr_cnt + 1;
      if (ARF_RegSel[2]) pc <= arf_op(pc, ARF_FunSel, ldv);
      if (ARF_RegSel[1]) ar <= arf_op(ar, ARF_FunSel, ldv);
      if (ARF_RegSel[0]) sp <= arf_op(sp, ARF_FunSel, ldv);
    end
  end

  // ---- checking ----
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Step negedges until EXEC shows the given instruction; n = cycles taken,
  // 0 if the bound expired.
  task automatic exec_wait(input logic [15:0] irv, output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge Clock);
      if (T_State == 3'd3 && IROut == irv) begin
        n = i;
        break;
      end
    end
  endtask

  int n, w0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // 0: LDI R2,0x2A  2: ADD R1,R2,R3  4: INC R3  6: illegal  8: BRA 0x40  0x40: HLT
    mem[0] = 8'h2A;    mem[1] = 8'h05;
    mem[2] = 8'h53;    mem[3] = 8'h14;
    mem[4] = 8'h00;    mem[5] = 8'h2A;
    mem[6] = 8'h00;    mem[7] = 8'h3F;
    mem[8] = 8'h40;    mem[9] = 8'h00;
    mem[8'h40] = 8'h00; mem[8'h41] = 8'h30;

    Reset = 1'b1;
    #1 Reset = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    chk("rst_state", T_State, 0);
    chk("rst_cs", Mem_CS, 1);
    chk("rst_regsel", RF_RegSel, 0);
    chk("rst_funsel", RF_FunSel, 3'b010);
    chk("rst_halted", Halted, 0);

    Reset = 1'b1;
    #1;
    chk("init_rf_regsel", RF_RegSel, 4'b1111);
    chk("init_scrsel", RF_ScrSel, 4'b1111);
    chk("init_arf_regsel", ARF_RegSel, 3'b111);
    chk("init_rf_fun", RF_FunSel, 3'b011);
    chk("init_arf_fun", ARF_FunSel, 3'b011);

    @(negedge Clock);
    chk("fl_state", T_State, 1);
    chk("fl_outd", ARF_OutDSel, 2'b00);
    chk("fl_lh", IR_LH, 0);
    chk("fl_cs", Mem_CS, 0);
    chk("fl_irw", IR_Write, 1);
    chk("fl_pcinc", {ARF_RegSel, ARF_FunSel}, {3'b100, 3'b001});
    chk("fl_pc_cleared", pc, 8'h00);
    @(negedge Clock);
    chk("fh_state", T_State, 2);
    chk("fh_lh", IR_LH, 1);
    @(negedge Clock);
    chk("ldi_state", T_State, 3);
    chk("ldi_ir", IROut, 16'h052A);
    chk("ldi_regsel", RF_RegSel, 4'b0100);
    chk("ldi_muxa", MuxASel, 2'b11);
    chk("ldi_fun", RF_FunSel, 3'b010);
    chk("ldi_pc", pc, 8'h02);

    exec_wait(16'h1453, n);
    chk("add_lat", n, 3);
    chk("add_outa", RF_OutASel, 3'b001);
    chk("add_outb", RF_OutBSel, 3'b010);
    chk("add_alu", ALU_FunSel, 5'b10100);
    chk("add_wf", ALU_WF, 1);
    chk("add_regsel", RF_RegSel, 4'b1000);
    chk("add_muxa", MuxASel, 2'b00);

    exec_wait(16'h2A00, n);
    chk("inc_lat", n, 3);
    chk("inc_regsel", RF_RegSel, 4'b0010);
    chk("inc_fun", RF_FunSel, 3'b001);

    exec_wait(16'h3F00, n);
    chk("nop_lat", n, 3);
    chk("nop_ctl", {RF_RegSel, ARF_RegSel, Mem_CS, IR_Write, ALU_WF}, {4'b0, 3'b0, 1'b1, 1'b0, 1'b0});
    @(negedge Clock);
    chk("nop_next", T_State, 1);

    exec_wait(16'h0040, n);
    chk("bra_lat", n, 2);
    chk("bra_arf", ARF_RegSel, 3'b100);
    chk("bra_muxb", MuxBSel, 2'b11);
    chk("bra_fun", ARF_FunSel, 3'b010);
    @(negedge Clock);
    chk("bra_fl_state", T_State, 1);
    chk("bra_fl_outd", ARF_OutDSel, 2'b00);
    chk("bra_pc", pc, 8'h40);

    exec_wait(16'h3000, n);
    chk("hlt_lat", n, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      chk("halt_flag", Halted, 1);
      chk("halt_state", T_State, 4);
      chk("halt_idle", {RF_RegSel, ARF_RegSel, Mem_CS, IR_Write, RF_FunSel},
          {4'b0, 3'b0, 1'b1, 1'b0, 3'b010});
    end

    // Replace HLT with ST R1 and restart from reset.
    mem[8'h40] = 8'h00; mem[8'h41] = 8'h0C;
    Reset = 1'b0;
    #1;
    chk("halt_rst_flag", Halted, 0);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("restart_state", T_State, 0);
    chk("restart_init", RF_RegSel, 4'b1111);

    exec_wait(16'h0C00, n);
    chk("st_found", (n != 0), 1);
    chk("st_cs", Mem_CS, 0);
    chk("st_wr", Mem_WR, 1);
    chk("st_path", {RF_OutASel, ALU_FunSel, MuxCSel, ARF_OutDSel}, {3'b000, 5'b10000, 1'b0, 2'b10});
    #2 Reset = 1'b0;
    #1;
    chk("strst_cs", Mem_CS, 1);
    chk("strst_wr", Mem_WR, 0);
    chk("strst_state", T_State, 0);
    w0 = wr_cnt;
    @(posedge Clock);
    #1;
    chk("strst_nowrite", wr_cnt, w0);
    chk("no_writes", wr_cnt, 0);
    Reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
